// File: rtl/scariv_pkg.sv
// Shared SCARIV parameters: register classes, data widths and rename-id space.
// Also holds the generic writeback entry carried from execution pipes to the register file.
package scariv_pkg;

  typedef enum logic {
    GPR = 1'b0,
    FPR = 1'b1
  } reg_type_t;

  localparam int XLEN_W        = 64;
  localparam int FLEN_W        = 64;
  localparam int XPR_RNID_SIZE = 128;
  localparam int FPR_RNID_SIZE = 128;

  localparam int WB_RNID_W = $clog2((XPR_RNID_SIZE > FPR_RNID_SIZE) ? XPR_RNID_SIZE : FPR_RNID_SIZE);
  localparam int WB_DATA_W = (XLEN_W > FLEN_W) ? XLEN_W : FLEN_W;

  // Widest form; modules bound to one register class declare a local typedef of the same shape.
  typedef struct packed {
    logic [WB_RNID_W-1:0] rnid;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/scariv_regwrite_if.sv
// One register-file write port: valid, destination physical register and data.
interface regwrite_if #(
  parameter int RNID_W = 7,
  parameter int WIDTH  = 64
);
  logic              valid;
  logic [RNID_W-1:0] rnid;
  logic [WIDTH-1:0]  data;

  modport master (output valid, rnid, data);
  modport slave  (input  valid, rnid, data);
endinterface

// File: rtl/scariv_wb_src_fifo.sv
// Small per-source writeback FIFO with wrapping pointers and an explicit occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module scariv_wb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_data,
  output logic [CNT_W-1:0] o_count,
  output logic [W-1:0]     o_head
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed when count is non-zero.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/scariv_regwrite_arbiter.sv
// Writeback arbiter: buffers results from SRC_SIZE pipes and drains up to WR_PORT_SIZE
// of them per cycle onto the register-file write ports, round-robin across sources.
module scariv_regwrite_arbiter
  import scariv_pkg::*;
#(
  parameter reg_type_t REG_TYPE     = GPR,
  parameter int        SRC_SIZE     = 8,
  parameter int        WR_PORT_SIZE = 5,
  parameter int        FIFO_DEPTH   = 2,
  localparam int       WIDTH        = (REG_TYPE == GPR) ? XLEN_W : FLEN_W,
  localparam int       RNID_SIZE    = (REG_TYPE == GPR) ? XPR_RNID_SIZE : FPR_RNID_SIZE,
  localparam int       RNID_W       = $clog2(RNID_SIZE)
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_flush,
  input  logic [SRC_SIZE-1:0]              i_src_valid,
  output logic [SRC_SIZE-1:0]              o_src_ready,
  input  logic [SRC_SIZE-1:0][RNID_W-1:0]  i_src_rnid,
  input  logic [SRC_SIZE-1:0][WIDTH-1:0]   i_src_data,
  regwrite_if.master                       regwrite [WR_PORT_SIZE],
  output logic                             o_drop_cnt_inc
);

  localparam int SRC_W   = $clog2(SRC_SIZE);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int PORT_CW = $clog2(WR_PORT_SIZE + 1);

  typedef struct packed {
    logic [RNID_W-1:0] rnid;
    logic [WIDTH-1:0]  data;
  } wb_local_t;

  wb_local_t         ent_in   [SRC_SIZE];
  wb_local_t         head     [SRC_SIZE];
  logic [CNT_W-1:0]  count    [SRC_SIZE];
  logic [SRC_SIZE-1:0] push, pop, nonempty;

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WR_PORT_SIZE-1:0] port_vld;
  logic [SRC_W-1:0]  port_sel  [WR_PORT_SIZE];
  logic [RNID_W-1:0] port_rnid [WR_PORT_SIZE];
  logic [WIDTH-1:0]  port_data [WR_PORT_SIZE];

  logic [SRC_W:0]     cand_ext;
  logic [SRC_W-1:0]   cand;
  logic [PORT_CW-1:0] n_gnt;
  logic               rnid_dup;

  for (genvar s = 0; s < SRC_SIZE; s++) begin : g_src
    logic skip_zero;

    // rnid 0 is the hard-wired zero register; such results are consumed but never written.
    assign skip_zero      = (REG_TYPE == GPR) && (i_src_rnid[s] == '0);
    assign ent_in[s]      = '{rnid: i_src_rnid[s], data: i_src_data[s]};
    assign o_src_ready[s] = (count[s] < CNT_W'(FIFO_DEPTH));
    assign push[s]        = i_src_valid[s] & o_src_ready[s] & ~i_flush & ~skip_zero;
    assign nonempty[s]    = (count[s] != '0);

    scariv_wb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(wb_local_t))
    ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_flush   (i_flush),
      .i_push    (push[s]),
      .i_pop     (pop[s]),
      .i_data    (ent_in[s]),
      .o_count   (count[s]),
      .o_head    (head[s])
    );
  end

  // Scan sources from rr_ptr upward, packing the first WR_PORT_SIZE non-empty ones onto ports.
  always_comb begin
    pop      = '0;
    port_vld = '0;
    for (int p = 0; p < WR_PORT_SIZE; p++) port_sel[p] = '0;
    rr_ptr_d = rr_ptr_q;
    n_gnt    = '0;
    cand_ext = '0;
    cand     = '0;
    for (int i = 0; i < SRC_SIZE; i++) begin
      cand_ext = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
      if (cand_ext >= (SRC_W+1)'(SRC_SIZE)) cand_ext = cand_ext - (SRC_W+1)'(SRC_SIZE);
      cand = cand_ext[SRC_W-1:0];
      if (nonempty[cand] && (n_gnt < PORT_CW'(WR_PORT_SIZE))) begin
        pop[cand]       = 1'b1;
        port_vld[n_gnt] = 1'b1;
        port_sel[n_gnt] = cand;
        rr_ptr_d        = (cand == SRC_W'(SRC_SIZE - 1)) ? '0 : cand + SRC_W'(1);
        n_gnt           = n_gnt + PORT_CW'(1);
      end
    end
    if (i_flush) rr_ptr_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rr_ptr_q <= '0;
    else            rr_ptr_q <= rr_ptr_d;
  end

  for (genvar p = 0; p < WR_PORT_SIZE; p++) begin : g_port
    assign port_rnid[p]      = port_vld[p] ? head[port_sel[p]].rnid : '0;
    assign port_data[p]      = port_vld[p] ? head[port_sel[p]].data : '0;
    assign regwrite[p].valid = port_vld[p];
    assign regwrite[p].rnid  = port_rnid[p];
    assign regwrite[p].data  = port_data[p];
  end

  assign o_drop_cnt_inc = i_flush & (|nonempty);

  // Renaming upstream guarantees no two in-flight results share a destination.
  always_comb begin
    rnid_dup = 1'b0;
    for (int a = 0; a < WR_PORT_SIZE; a++) begin
      for (int b = a + 1; b < WR_PORT_SIZE; b++) begin
        if (port_vld[a] && port_vld[b] && (port_rnid[a] == port_rnid[b])) rnid_dup = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (!rnid_dup);
    end
  end

endmodule
